// File: rtl/srv1_pkg.sv
// Shared SRV1 decode/execute types: opcodes, ALU operations, immediate formats
// and the packed control word carried down the pipeline.
package srv1_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [2:0] funct3;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op: ALU_ADD, funct3: 3'b000, alu_src_imm: 1'b0, alu_src_pc: 1'b0,
    reg_we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, branch: 1'b0, jal: 1'b0,
    jalr: 1'b0, illegal: 1'b0
  };

  // alt selects SUB/SRA; the caller decides when instr[30] is meaningful.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
interface decode_stage_if;
  import srv1_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  ctrl_t           out_ctrl;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl
  );
endinterface

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the RV32I instruction formats.
module imm_gen
  import srv1_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// SRV1 decode stage: decoder, load-use bubble, flush and the decoded pipeline
// register feeding execute alongside the register file's registered reads.
module decode_stage
  import srv1_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus,
  output logic [4:0]    rf_rs1_addr,
  output logic [4:0]    rf_rs2_addr,
  output logic          rf_clk_en
);

  opcode_e         opcode;
  imm_fmt_e        imm_fmt;
  ctrl_t           dec_ctrl;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [4:0]      dec_rd;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic            advance;
  logic            hazard;

  assign opcode = opcode_e'(bus.in_instr[6:0]);

  always_comb begin
    dec_ctrl        = CTRL_NOP;
    dec_ctrl.funct3 = bus.in_instr[14:12];
    imm_fmt         = IMM_NONE;
    uses_rs1        = 1'b1;
    uses_rs2        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_ctrl.alu_op      = ALU_PASS_B;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_we      = 1'b1;
        imm_fmt              = IMM_U;
        uses_rs1             = 1'b0;
      end
      OPC_AUIPC: begin
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.alu_src_pc  = 1'b1;
        dec_ctrl.reg_we      = 1'b1;
        imm_fmt              = IMM_U;
        uses_rs1             = 1'b0;
      end
      OPC_JAL: begin
        dec_ctrl.jal         = 1'b1;
        dec_ctrl.reg_we      = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.alu_src_pc  = 1'b1;
        imm_fmt              = IMM_J;
        uses_rs1             = 1'b0;
      end
      OPC_JALR: begin
        dec_ctrl.jalr        = 1'b1;
        dec_ctrl.reg_we      = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        imm_fmt              = IMM_I;
      end
      OPC_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        imm_fmt         = IMM_B;
        uses_rs2        = 1'b1;
      end
      OPC_LOAD: begin
        dec_ctrl.mem_rd      = 1'b1;
        dec_ctrl.reg_we      = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        imm_fmt              = IMM_I;
      end
      OPC_STORE: begin
        dec_ctrl.mem_wr      = 1'b1;
        dec_ctrl.alu_src_imm = 1'b1;
        imm_fmt              = IMM_S;
        uses_rs2             = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is part of the immediate except for the shift-right pair
        dec_ctrl.alu_op = alu_from_funct3(bus.in_instr[14:12],
                            bus.in_instr[14:12] == 3'b101 && bus.in_instr[30]);
        dec_ctrl.alu_src_imm = 1'b1;
        dec_ctrl.reg_we      = 1'b1;
        imm_fmt              = IMM_I;
      end
      OPC_OP: begin
        dec_ctrl.alu_op = alu_from_funct3(bus.in_instr[14:12], bus.in_instr[30]);
        dec_ctrl.reg_we = 1'b1;
        uses_rs2        = 1'b1;
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        dec_ctrl.illegal = 1'b1;
        imm_fmt          = IMM_I;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  assign dec_rd  = dec_ctrl.reg_we ? bus.in_instr[11:7]  : '0;
  assign dec_rs1 = uses_rs1        ? bus.in_instr[19:15] : '0;
  assign dec_rs2 = uses_rs2        ? bus.in_instr[24:20] : '0;

  imm_gen u_imm_gen (
    .instr (bus.in_instr[31:7]),
    .fmt   (imm_fmt),
    .imm   (dec_imm)
  );

  assign advance = !bus.out_valid || bus.out_ready;
  // Unused source fields decode to x0 and out_rd is non-zero, so they never match.
  assign hazard  = bus.out_valid && bus.out_ctrl.mem_rd && (bus.out_rd != '0) &&
                   bus.out_ready && bus.in_valid &&
                   ((dec_rs1 == bus.out_rd) || (dec_rs2 == bus.out_rd));

  assign bus.in_ready = !rst && advance && (!hazard || bus.flush);
  assign rf_clk_en    = !rst;
  assign rf_rs1_addr  = advance ? dec_rs1 : bus.out_rs1;
  assign rf_rs2_addr  = advance ? dec_rs2 : bus.out_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pc    <= '0;
      bus.out_imm   <= '0;
      bus.out_rd    <= '0;
      bus.out_rs1   <= '0;
      bus.out_rs2   <= '0;
      bus.out_ctrl  <= CTRL_NOP;
    end else if (bus.flush || hazard) begin
      bus.out_valid <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_pc   <= bus.in_pc;
        bus.out_imm  <= dec_imm;
        bus.out_rd   <= dec_rd;
        bus.out_rs1  <= dec_rs1;
        bus.out_rs2  <= dec_rs2;
        bus.out_ctrl <= dec_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan scenarios plus randomized traffic
// against an ISA-level decode reference and transaction-level pipeline model.
module tb_decode_stage;
  import srv1_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rf_rs1_addr;
  logic [4:0] rf_rs2_addr;
  logic       rf_clk_en;

  decode_stage_if bus ();

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_clk_en   (rf_clk_en)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ref_t;

  typedef logic [32 + $bits(ref_t) - 1:0] snap_t;

  logic        m_valid;
  logic [31:0] m_pc;
  ref_t        m_d;

  // Decode straight from the RV32I encoding tables; immediates via arithmetic shifts.
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    logic signed [31:0] t;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic use1, use2;
    logic [2:0] f3;
    alu_op_e base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = w[14:12];
    t = w;                                                        imm_i = t >>> 20;
    t = {w[31:25], w[11:7], 20'b0};                               imm_s = t >>> 20;
    t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0};            imm_b = t >>> 19;
    t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0};          imm_j = t >>> 11;
    imm_u = w & 32'hFFFF_F000;
    r = '0;
    r.ctrl = CTRL_NOP;
    r.ctrl.funct3 = f3;
    use1 = 1'b1;
    use2 = 1'b0;
    case (w[6:0])
      7'h37: begin r.ctrl.alu_op = ALU_PASS_B; r.ctrl.alu_src_imm = 1; r.ctrl.reg_we = 1; r.imm = imm_u; use1 = 0; end
      7'h17: begin r.ctrl.alu_src_imm = 1; r.ctrl.alu_src_pc = 1; r.ctrl.reg_we = 1; r.imm = imm_u; use1 = 0; end
      7'h6F: begin r.ctrl.jal = 1; r.ctrl.reg_we = 1; r.ctrl.alu_src_imm = 1; r.ctrl.alu_src_pc = 1; r.imm = imm_j; use1 = 0; end
      7'h67: begin r.ctrl.jalr = 1; r.ctrl.reg_we = 1; r.ctrl.alu_src_imm = 1; r.imm = imm_i; end
      7'h63: begin r.ctrl.branch = 1; r.ctrl.alu_op = ALU_SUB; r.imm = imm_b; use2 = 1; end
      7'h03: begin r.ctrl.mem_rd = 1; r.ctrl.reg_we = 1; r.ctrl.alu_src_imm = 1; r.imm = imm_i; end
      7'h23: begin r.ctrl.mem_wr = 1; r.ctrl.alu_src_imm = 1; r.imm = imm_s; use2 = 1; end
      7'h13: begin
        r.ctrl.alu_op = (f3 == 3'd5 && w[30]) ? ALU_SRA : base[f3];
        r.ctrl.alu_src_imm = 1; r.ctrl.reg_we = 1; r.imm = imm_i;
      end
      7'h33: begin
        r.ctrl.alu_op = (f3 == 3'd0 && w[30]) ? ALU_SUB : (f3 == 3'd5 && w[30]) ? ALU_SRA : base[f3];
        r.ctrl.reg_we = 1; use2 = 1;
      end
      7'h0F: ;
      7'h73: begin r.ctrl.illegal = 1; r.imm = imm_i; end
      default: r.ctrl.illegal = 1;
    endcase
    r.rd  = r.ctrl.reg_we ? w[11:7]  : 5'd0;
    r.rs1 = use1          ? w[19:15] : 5'd0;
    r.rs2 = use2          ? w[24:20] : 5'd0;
    return r;
  endfunction

  function automatic logic exp_advance();
    return !m_valid || bus.out_ready;
  endfunction

  function automatic logic exp_hazard();
    ref_t d;
    d = ref_decode(bus.in_instr);
    return m_valid && m_d.ctrl.mem_rd && m_d.rd != 5'd0 && bus.out_ready && bus.in_valid &&
           ((d.rs1 != 5'd0 && d.rs1 == m_d.rd) || (d.rs2 != 5'd0 && d.rs2 == m_d.rd));
  endfunction

  function automatic logic exp_in_ready();
    return !rst && exp_advance() && (!exp_hazard() || bus.flush);
  endfunction

  function automatic logic [9:0] exp_rf_addrs();
    ref_t d;
    d = ref_decode(bus.in_instr);
    return exp_advance() ? {d.rs1, d.rs2} : {m_d.rs1, m_d.rs2};
  endfunction

  function automatic snap_t dut_snap();
    return {bus.out_pc, bus.out_ctrl, bus.out_imm, bus.out_rd, bus.out_rs1, bus.out_rs2};
  endfunction

  function automatic snap_t model_snap();
    return {m_pc, m_d};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc = '0;
    m_d = '0;
    m_d.ctrl = CTRL_NOP;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.flush = fl;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    logic adv, haz;
    @(posedge clk);
    if (!rst) begin
      adv = exp_advance();
      haz = exp_hazard();
      if (bus.flush || haz) m_valid = 1'b0;
      else if (adv) begin
        m_valid = bus.in_valid;
        if (bus.in_valid) begin
          m_pc = bus.in_pc;
          m_d = ref_decode(bus.in_instr);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (bus.out_valid !== 1'b0 || dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b %h want v=0 %h", bus.out_valid, dut_snap(), model_snap());
    end
    vectors++;
    if (bus.in_ready !== 1'b0 || rf_clk_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_clken: got %b%b want 00", bus.in_ready, rf_clk_en);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    drive(1, 32'h0050_0093, 32'h100, 0, 1);
    vectors++;
    if (rf_rs1_addr !== 5'd0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_accept: got rs1a=%0d rdy=%b want 0 1", rf_rs1_addr, bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1 || bus.out_rd !== 5'd1 || bus.out_rs1 !== 5'd0 || bus.out_imm !== 32'd5 ||
        bus.out_ctrl.alu_op !== ALU_ADD || bus.out_ctrl.alu_src_imm !== 1 || bus.out_ctrl.reg_we !== 1) begin
      miscompares++;
      $display("FAIL addi_decode: got v=%b rd=%0d rs1=%0d imm=%h ctrl=%h", bus.out_valid, bus.out_rd,
               bus.out_rs1, bus.out_imm, bus.out_ctrl);
    end
    drive(1, 32'h0020_A423, 32'h104, 0, 1);
    tick();
    vectors++;
    if (bus.out_imm !== 32'd8 || bus.out_ctrl.mem_wr !== 1 || bus.out_rd !== 5'd0) begin
      miscompares++;
      $display("FAIL sw_decode: got imm=%h mem_wr=%b rd=%0d want 8 1 0", bus.out_imm, bus.out_ctrl.mem_wr, bus.out_rd);
    end
    drive(1, 32'hFE00_0EE3, 32'h108, 0, 1);
    tick();
    vectors++;
    if (bus.out_imm !== 32'hFFFF_FFFC || bus.out_ctrl.branch !== 1) begin
      miscompares++;
      $display("FAIL beq_decode: got imm=%h branch=%b want fffffffc 1", bus.out_imm, bus.out_ctrl.branch);
    end
    vectors++;
    if (bus.out_valid !== m_valid || dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL beq_model: got %h want %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_load_use();
    drive(1, 32'h0000_A103, 32'h200, 0, 1);
    tick();
    drive(1, 32'h0011_01B3, 32'h204, 0, 1);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_stall: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_bubble: got out_valid=%b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_resume: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_rd !== 5'd3) begin
      miscompares++;
      $display("FAIL load_use_issue: got v=%b pc=%h rd=%0d want 1 204 3", bus.out_valid, bus.out_pc, bus.out_rd);
    end
    drive(1, 32'h0000_A103, 32'h208, 0, 1);
    tick();
    drive(1, 32'h0010_01B3, 32'h20C, 0, 1);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL no_hazard_ready: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h20C) begin
      miscompares++;
      $display("FAIL no_hazard_issue: got v=%b pc=%h want 1 20c", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 32'h0070_8293, 32'h300, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0011_01B3, 32'h304, 0, 0);
      vectors++;
      if (bus.in_ready !== 1'b0 || rf_rs1_addr !== 5'd1 || rf_clk_en !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_cycle%0d: got rdy=%b rs1a=%0d clken=%b want 0 1 1", i, bus.in_ready, rf_rs1_addr, rf_clk_en);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd5 || dut_snap() !== model_snap()) begin
        miscompares++;
        $display("FAIL bp_stable%0d: got v=%b %h want 1 %h", i, bus.out_valid, dut_snap(), model_snap());
      end
    end
    drive(1, 32'h0011_01B3, 32'h304, 0, 1);
    vectors++;
    if (rf_rs1_addr !== 5'd2 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got rs1a=%0d rdy=%b want 2 1", rf_rs1_addr, bus.in_ready);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 32'h0050_0093, 32'h400, 0, 1);
    tick();
    drive(1, 32'h0020_A423, 32'h404, 1, 1);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_ready: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    drive(0, 32'h0, 32'h0, 0, 1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_kill: got out_valid=%b want 0", bus.out_valid);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_never_appears: got out_valid=%b want 0", bus.out_valid);
    end
    drive(1, 32'h0050_0093, 32'h408, 0, 1);
    tick();
    drive(1, 32'h0020_A423, 32'h40C, 1, 0);
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stalled: got out_valid=%b want 0", bus.out_valid);
    end
    drive(1, 32'h0000_A103, 32'h410, 0, 1);
    tick();
    drive(1, 32'h0011_01B3, 32'h414, 1, 1);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_over_hazard: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    drive(1, 32'h0011_01B3, 32'h418, 0, 1);
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h418) begin
      miscompares++;
      $display("FAIL flush_hazard_no_bubble: got v=%b pc=%h want 1 418", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h0050_0093, 32'h500, 0, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== CTRL_NOP || bus.in_ready !== 1'b0 || rf_clk_en !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b ctrl=%h rdy=%b clken=%b want 0 %h 0 0",
               bus.out_valid, bus.out_ctrl, bus.in_ready, rf_clk_en, CTRL_NOP);
    end
    model_reset();
    drive(0, 32'h0, 32'h0, 0, 1);
    tick();
    rst = 1'b0;
    drive(1, 32'h0020_A423, 32'h504, 0, 1);
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || dut_snap() !== model_snap()) begin
      miscompares++;
      $display("FAIL post_reset_first: got v=%b %h want 1 %h", bus.out_valid, dut_snap(), model_snap());
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                              7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};
    logic [31:0] w;
    w = $urandom;
    w[6:0]   = opcs[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_random();
    logic v, fl, ordy;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 9) < 8);
      fl   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(v, rand_instr(), $urandom, fl, ordy);
      vectors++;
      if (bus.in_ready !== exp_in_ready() || rf_clk_en !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got rdy=%b clken=%b want %b 1", i, bus.in_ready, rf_clk_en, exp_in_ready());
      end
      vectors++;
      if ({rf_rs1_addr, rf_rs2_addr} !== exp_rf_addrs()) begin
        miscompares++;
        $display("FAIL rand_rf_addr[%0d]: got %h want %h", i, {rf_rs1_addr, rf_rs2_addr}, exp_rf_addrs());
      end
      tick();
      vectors++;
      if (bus.out_valid !== m_valid || (m_valid && dut_snap() !== model_snap())) begin
        miscompares++;
        $display("FAIL rand_out[%0d]: got v=%b %h want v=%b %h", i, bus.out_valid, dut_snap(), m_valid, model_snap());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_decode();
    test_load_use();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage for the SRV1 RV32I pipeline. It sits between fetch and execute: accepts one instruction per cycle over a valid/ready handshake, drives the register file's read-address ports, and holds a decoded pipeline register. The execute stage takes its operands directly from the register file's registered read outputs, which line up with this stage's output register. It also inserts the single load-use bubble and handles flush from execute.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts `in_instr`/`in_pc` this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  execute redirect; kill held and incoming instruction
- rf_rs1_addr, rf_rs2_addr  out  5  register file read addresses (combinational)
- rf_clk_en  out  1  register file clock enable; constant 1 outside reset
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts this cycle
- out_pc  out  XLEN  instruction address
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by format)
- out_rd, out_rs1, out_rs2  out  5 each  register indices (rd forced 0 when not written)
- out_ctrl  out  ctrl_t  packed control: alu_op, funct3, alu_src_imm, alu_src_pc, reg_we, mem_rd, mem_wr, branch, jal, jalr, illegal

## Operation
- advance = !out_valid || out_ready.
- Hazard: out_valid && out_ctrl.mem_rd && out_rd != 0 && out_ready && in_valid && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd)). uses_rs1 is 0 for LUI/AUIPC/JAL; uses_rs2 is 1 only for OP, STORE, BRANCH.
- in_ready = advance && (!hazard || flush).
- Edge, priority order: flush -> out_valid<=0, incoming (if any) discarded; hazard -> out_valid<=0 (bubble); in_valid && advance -> load decoded fields, out_valid<=1; advance && !in_valid -> out_valid<=0; else hold.
- Read addresses: rf_rs*_addr = advance ? incoming rs fields : out_rs1/out_rs2. A held instruction re-reads each cycle, so writebacks during a stall reach its operands through the register file's forwarding. Do not gate rf_clk_en; the register file writes only when it is high.
- Unused source fields (e.g. rs2 of I-type) drive address 0.
- Decode covers all RV32I opcodes plus FENCE (as NOP) and ECALL/EBREAK (illegal=1, reg_we=0). An unknown opcode sets illegal=1 and clears reg_we/mem_rd/mem_wr/branch/jal/jalr. Illegal instructions still flow downstream.
- Immediates: B/J bit 0 = 0; U = instr[31:12]<<12; all sign-extended from instr[31].

## Timing
- Latency 1: an instruction accepted at edge N appears on out_* after N. The register file read data for it is valid in the same cycle.
- Throughput 1/cycle with no hazard; load-use costs exactly 1 bubble.
- Reset (async assert, synchronous release): out_valid=0, all out_* = 0, out_ctrl = CTRL_NOP, in_ready=0 and rf_clk_en=0 while rst is high.
- Flush together with hazard: flush wins, no bubble is counted.
- Flush while out_ready=0: the held instruction is still dropped.
- out_* must stay stable while out_valid && !out_ready.

## Structure
- srv1_pkg: opcode_e (7-bit RV32I opcodes), alu_op_e (4-bit: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), imm_fmt_e, ctrl_t packed struct, CTRL_NOP constant. This package is shared with the execute stage.
- Sub-module imm_gen: combinational, maps (instr, imm_fmt_e) to XLEN immediate.
- decode_stage holds the decoder case, hazard logic and the output register.

## Test plan
- Decode: in 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, out_rd=1, out_rs1=0, out_imm=5, alu_op=ADD, alu_src_imm=1, reg_we=1; rf_rs1_addr=0 at accept.
- Immediates: in 0x0020A423 (sw x2,8(x1)) -> out_imm=8, mem_wr=1, out_rd=0. In 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, branch=1.
- Load-use: 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) with out_ready=1 -> one cycle out_valid=0 and in_ready=0, then add issues. Repeat with add x3,x0,x1 -> no bubble.
- Backpressure: hold out_ready=0 for 3 cycles while writeback writes x1 -> out_* stable, rf_rs1_addr=out_rs1, in_ready=0.
- Flush: flush with valid held and incoming -> out_valid=0 next cycle, in_ready=1 that cycle, the incoming instruction never appears.
- Reset: assert rst mid-stream asynchronously -> out_valid=0 and out_ctrl=CTRL_NOP before the next edge. After release, the first accepted instruction appears after 1 cycle.
